sti_arbiter: RTL and testbench
==============================

// Module: sti_arbiter
// PURPOSE
// - Two-master, one-slave arbiter for the simple transaction interface (STI).
// - Shares the single memory STI slave between master 0 (MAU mem port, CPU) and master 1 (DMA/video fetch).
// - Latches each master's single-cycle request, grants one at a time and re-issues it to the slave.
// - Routes read data and completion back to the granted master.
// PARAMETERS
// - AW       16  address width
// - DW       16  data width
// - TO_CYC   0   completion timeout in cycles (0 = no timeout)
// PORTS
// - clk            in   1   clock
// - arst_n         in   1   asynchronous active-low reset
// - m0_init_txn    in   1   master 0 request pulse (exactly one cycle)
// - m0_wtxn        in   1   master 0 write flag
// - m0_addr        in   AW  master 0 address
// - m0_wdata       in   DW  master 0 write data
// - m0_rdata       out  DW  master 0 read data, valid while m0_rdy=1
// - m0_rdy         out  1   master 0 completion pulse
// - m1_*           --  --   same six signals for master 1
// - slv_init_txn   out  1   slave request pulse
// - slv_wtxn       out  1   slave write flag
// - slv_addr       out  AW  slave address
// - slv_wdata      out  DW  slave write data
// - slv_rdata      in   DW  slave read data
// - slv_rdy        in   1   slave completion pulse
// - err            out  1   sticky: request overrun or timeout
// BEHAVIOUR
// - Reset values: all outputs 0; pending bits, request registers, grant, err and counter cleared; state IDLE.
// - Request capture: mX_init_txn=1 stores {wtxn,addr,wdata} and sets pend[X] on the next edge.
// - Overrun: mX_init_txn while pend[X]=1 is dropped and sets err; the stored request is unchanged.
// - pend[X] clears on the cycle its completion is returned.
// - If a new init arrives in that same cycle, set wins and the new request is captured.
// - FSM, IDLE:
//   - If no pend bit is set, stay in IDLE.
//   - Otherwise select a winner and register gnt.
//   - Next cycle: ISSUE.
// - FSM, ISSUE:
//   - Drive slv_init_txn=1 for one cycle with the granted request on slv_*.
//   - Next cycle: WAIT.
// - FSM, WAIT:
//   - slv_* hold the granted request.
//   - On slv_rdy: mG_rdy=1 and mG_rdata=slv_rdata in the same cycle (combinational), clear pend[G], go to IDLE.
// - slv_rdy outside WAIT is ignored. This covers a stale completion after a reset mid-transaction.
// - Latency: init at cycle N gives slv_init_txn at N+2 earliest. Master rdy coincides with slv_rdy.
// - Non-granted master: rdy=0, rdata=0.
// - Arbitration: both pending in IDLE -> master 0 wins (fixed priority, default build).
// - Timeout (TO_CYC>0):
//   - WAIT counts cycles from 0.
//   - At count==TO_CYC-1 with no slv_rdy: mG_rdy=1, mG_rdata={DW{1'b1}}, set err, clear pend[G], go to IDLE.
// - Reset mid-operation: returns to IDLE immediately, all pending requests lost, no rdy issued.
// CONFIGURATION
// - STI_ARB_RR_EN defined:
//   - Round-robin arbitration.
//   - A 1-bit last-grant register is updated each grant.
//   - On a tie the master not granted last wins. The register resets to 1, so master 0 wins the first tie.
// - STI_ARB_RR_EN undefined: fixed priority, master 0 always wins ties. No last-grant register.
// TESTING
// - m0 read addr 16'h3000, slave rdy 3 cycles after init with rdata 16'hABCD:
//   - slv_init_txn at N+2 with slv_wtxn=0.
//   - m0_rdy=1 and m0_rdata=16'hABCD the same cycle; m1_rdy stays 0.
// - m0 and m1 init in the same cycle, both writes (m0 16'h1111@16'h0010, m1 16'h2222@16'h0020):
//   - Fixed build: slave sees m0 then m1.
//   - RR build with 3 back-to-back tie rounds: grants alternate 0,1,0.
// - m1 issues a second init while its first is pending:
//   - err=1; only the first request reaches the slave; one m1_rdy.
// - TO_CYC=8, slave never asserts rdy:
//   - m0_rdy pulses 8 cycles into WAIT with rdata 16'hFFFF; err=1.
//   - Next pending request is then serviced normally.
// - arst_n low during WAIT, slave rdy arrives after release:
//   - No m0_rdy/m1_rdy; slv_init_txn stays 0; err=0.
// - m0 init coincident with its own previous m0_rdy:
//   - New request captured and serviced.
//   - Two slave transactions, two m0_rdy pulses.

Source files
------------

// File: rtl/sti_arbiter_if.sv
// ----------------------------------------------------------------------------
// sti_arbiter_if : simple transaction interface (STI) bundle
//
// One request/completion channel between an STI master and an STI slave.
//   init_txn  master->slave  single-cycle request pulse
//   wtxn      master->slave  write flag
//   addr      master->slave  address (AW bits)
//   wdata     master->slave  write data (DW bits)
//   rdata     slave->master  read data, valid while rdy=1
//   rdy       slave->master  single-cycle completion pulse
// ----------------------------------------------------------------------------
interface sti_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          init_txn;
  logic          wtxn;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rdy;

  modport master (
    output init_txn, wtxn, addr, wdata,
    input  rdata, rdy
  );

  modport slave (
    input  init_txn, wtxn, addr, wdata,
    output rdata, rdy
  );
endinterface

// File: rtl/sti_arbiter.sv
// ----------------------------------------------------------------------------
// sti_arbiter : two-master / one-slave STI arbiter
//
// Latches one single-cycle request per master, grants one master at a time,
// re-issues the granted request to the shared slave and routes the slave's
// completion (and read data) back to the granted master.
//
// Ports
//   clk     in   clock
//   arst_n  in   asynchronous active-low reset
//   m0      STI slave side facing master 0 (CPU / MAU mem port)
//   m1      STI slave side facing master 1 (DMA / video fetch)
//   slv     STI master side driving the shared memory slave
//   err     out  sticky error: request overrun or completion timeout
//
// Parameters
//   AW, DW  address / data width
//   TO_CYC  completion timeout in WAIT cycles (0 = wait forever)
//
// Build option
//   STI_ARB_RR_EN  defined   : round-robin on ties (last-grant register)
//                  undefined : fixed priority, master 0 wins ties
// ----------------------------------------------------------------------------
module sti_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int TO_CYC = 0
) (
  input  logic           clk,
  input  logic           arst_n,
  sti_arbiter_if.slave   m0,
  sti_arbiter_if.slave   m1,
  sti_arbiter_if.master  slv,
  output logic           err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int             CW       = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [CW-1:0]  TO_LAST  = CW'((TO_CYC > 0) ? (TO_CYC - 1) : 0);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  state_t         state_r;
  logic [1:0]     pend_r;
  logic [1:0]     req_wtxn_r;
  logic [AW-1:0]  req_addr_r  [2];
  logic [DW-1:0]  req_wdata_r [2];
  logic           gnt_r;
  logic           err_r;
  logic [CW-1:0]  cnt_r;
  logic           slv_init_r;
  logic           slv_wtxn_r;
  logic [AW-1:0]  slv_addr_r;
  logic [DW-1:0]  slv_wdata_r;
`ifdef STI_ARB_RR_EN
  logic           last_r;
`endif

  logic [1:0]     init_s;
  logic           slv_done_s;
  logic           to_s;
  logic           done_s;
  logic [1:0]     done_vec_s;
  logic [1:0]     capture_s;
  logic [1:0]     overrun_s;
  logic           winner_s;
  logic [DW-1:0]  rsp_s;
  logic           m0_rdy_s;
  logic           m1_rdy_s;
  logic [DW-1:0]  m0_rdata_s;
  logic [DW-1:0]  m1_rdata_s;

  assign init_s = {m1.init_txn, m0.init_txn};

  // Completion detection: real slave completion or timeout, WAIT only.
  always_comb begin
    slv_done_s = 1'b0;
    to_s       = 1'b0;
    if (state_r == WAIT) begin
      slv_done_s = slv.rdy;
      if ((TO_CYC > 0) && !slv.rdy && (cnt_r == TO_LAST)) begin
        to_s = 1'b1;
      end else begin
        to_s = 1'b0;
      end
    end else begin
      slv_done_s = 1'b0;
    end
    done_s = slv_done_s | to_s;
  end

  // Per-master completion vector and request capture / overrun decode.
  // A completion returned in the same cycle as a new init frees the slot,
  // so the new request is captured instead of being treated as an overrun.
  always_comb begin
    done_vec_s = 2'b00;
    if (done_s) begin
      done_vec_s[gnt_r] = 1'b1;
    end else begin
      done_vec_s = 2'b00;
    end
    capture_s = init_s & (~pend_r | done_vec_s);
    overrun_s = init_s & pend_r & ~done_vec_s;
  end

  // Winner selection among pending requests.
  always_comb begin
    winner_s = 1'b0;
    if (pend_r == 2'b11) begin
`ifdef STI_ARB_RR_EN
      winner_s = ~last_r;
`else
      winner_s = 1'b0;
`endif
    end else if (pend_r[0]) begin
      winner_s = 1'b0;
    end else begin
      winner_s = 1'b1;
    end
  end

  // Completion routing: only the granted master sees rdy/rdata.
  always_comb begin
    rsp_s      = {DW{1'b0}};
    m0_rdy_s   = 1'b0;
    m1_rdy_s   = 1'b0;
    m0_rdata_s = {DW{1'b0}};
    m1_rdata_s = {DW{1'b0}};
    if (slv_done_s) begin
      rsp_s = slv.rdata;
    end else if (to_s) begin
      rsp_s = {DW{1'b1}};
    end else begin
      rsp_s = {DW{1'b0}};
    end
    if (done_s) begin
      if (gnt_r == 1'b0) begin
        m0_rdy_s   = 1'b1;
        m0_rdata_s = rsp_s;
      end else begin
        m1_rdy_s   = 1'b1;
        m1_rdata_s = rsp_s;
      end
    end else begin
      m0_rdy_s = 1'b0;
      m1_rdy_s = 1'b0;
    end
  end

  assign m0.rdy      = m0_rdy_s;
  assign m0.rdata    = m0_rdata_s;
  assign m1.rdy      = m1_rdy_s;
  assign m1.rdata    = m1_rdata_s;
  assign slv.init_txn = slv_init_r;
  assign slv.wtxn     = slv_wtxn_r;
  assign slv.addr     = slv_addr_r;
  assign slv.wdata    = slv_wdata_r;
  assign err          = err_r;

  // Request slots, sticky error and the IDLE/ISSUE/WAIT sequencer.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r        <= IDLE;
      pend_r         <= 2'b00;
      req_wtxn_r     <= 2'b00;
      req_addr_r[0]  <= {AW{1'b0}};
      req_addr_r[1]  <= {AW{1'b0}};
      req_wdata_r[0] <= {DW{1'b0}};
      req_wdata_r[1] <= {DW{1'b0}};
      gnt_r          <= 1'b0;
      err_r          <= 1'b0;
      cnt_r          <= {CW{1'b0}};
      slv_init_r     <= 1'b0;
      slv_wtxn_r     <= 1'b0;
      slv_addr_r     <= {AW{1'b0}};
      slv_wdata_r    <= {DW{1'b0}};
`ifdef STI_ARB_RR_EN
      last_r         <= 1'b1;
`endif
    end else begin
      // Set wins over clear so a coincident new request is kept.
      pend_r <= (pend_r & ~done_vec_s) | capture_s;

      if (capture_s[0]) begin
        req_wtxn_r[0]  <= m0.wtxn;
        req_addr_r[0]  <= m0.addr;
        req_wdata_r[0] <= m0.wdata;
      end
      if (capture_s[1]) begin
        req_wtxn_r[1]  <= m1.wtxn;
        req_addr_r[1]  <= m1.addr;
        req_wdata_r[1] <= m1.wdata;
      end

      if ((|overrun_s) || to_s) begin
        err_r <= 1'b1;
      end

      case (state_r)
        IDLE: begin
          cnt_r <= {CW{1'b0}};
          if (|pend_r) begin
            gnt_r       <= winner_s;
            slv_init_r  <= 1'b1;
            slv_wtxn_r  <= req_wtxn_r[winner_s];
            slv_addr_r  <= req_addr_r[winner_s];
            slv_wdata_r <= req_wdata_r[winner_s];
`ifdef STI_ARB_RR_EN
            last_r      <= winner_s;
`endif
            state_r     <= ISSUE;
          end else begin
            slv_init_r  <= 1'b0;
            state_r     <= IDLE;
          end
        end
        ISSUE: begin
          slv_init_r <= 1'b0;
          cnt_r      <= {CW{1'b0}};
          state_r    <= WAIT;
        end
        WAIT: begin
          slv_init_r <= 1'b0;
          if (done_s) begin
            cnt_r   <= {CW{1'b0}};
            state_r <= IDLE;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            state_r <= WAIT;
          end
        end
        default: begin
          slv_init_r <= 1'b0;
          cnt_r      <= {CW{1'b0}};
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sti_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sti_arbiter : scoreboard bench for sti_arbiter (TO_CYC = 8)
//
// Stimulus pushes each accepted request (with its expected completion data)
// onto a per-master queue. A negedge monitor checks every slave issue against
// the arbitration rule applied to the eligible queue heads, and every master
// completion against the queue head. A bench slave answers each issue after
// a programmable latency with rdata = addr ^ 16'h5A5A (or a fixed value).
// ----------------------------------------------------------------------------
module tb_sti_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic err;

  sti_arbiter_if #(.AW(AW), .DW(DW)) m0_bus ();
  sti_arbiter_if #(.AW(AW), .DW(DW)) m1_bus ();
  sti_arbiter_if #(.AW(AW), .DW(DW)) slv_bus ();

  sti_arbiter #(.AW(AW), .DW(DW), .TO_CYC(TO)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .m0     (m0_bus),
    .m1     (m1_bus),
    .slv    (slv_bus),
    .err    (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] r;
    int          c;
  } req_t;

  req_t q0[$];
  req_t q1[$];
  bit   inflight0, inflight1;
  int   owner = -1;
  logic last_g = 1'b1;
  logic err_exp = 1'b0;
  int   slv_cnt = 0;
  int   rdy_cnt0 = 0, rdy_cnt1 = 0;
  int   last_slv_cyc = 0;
  int   last_rdy_cyc0 = 0;
  int   slv_order[$];

  int   n_chk = 0;
  int   n_pass = 0;

  // slave model controls
  int          slv_lat = 1;
  bit          slv_rand = 1'b0;
  bit          slv_mute = 1'b0;
  bit          slv_fix_en = 1'b0;
  logic [15:0] slv_fix_val = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m0_bus.init_txn = 1'b0;
    m1_bus.init_txn = 1'b0;
  endtask

  // Drive one request for the current cycle and record what it should return.
  task automatic issue(input int m, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic acc);
    req_t r;
    r.w = w; r.a = a; r.d = d; r.c = cyc;
    if (slv_mute) begin
      r.r = 16'hFFFF;
      err_exp = 1'b1;
    end else if (slv_fix_en) begin
      r.r = slv_fix_val;
    end else begin
      r.r = a ^ 16'h5A5A;
    end
    if (m == 0) begin
      m0_bus.init_txn = 1'b1; m0_bus.wtxn = w; m0_bus.addr = a; m0_bus.wdata = d;
    end else begin
      m1_bus.init_txn = 1'b1; m1_bus.wtxn = w; m1_bus.addr = a; m1_bus.wdata = d;
    end
    if (acc) begin
      if (m == 0) q0.push_back(r);
      else        q1.push_back(r);
    end else begin
      err_exp = 1'b1;
    end
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    q0.delete();
    q1.delete();
    inflight0 = 1'b0;
    inflight1 = 1'b0;
    owner = -1;
    err_exp = 1'b0;
    last_g = 1'b1;
    repeat (2) tick();
    arst_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((q0.size() + q1.size()) != 0 && k < budget) begin
      tick();
      k++;
    end
    chk("drain", q0.size() + q1.size(), 0);
  endtask

  task automatic wait_slv(input int budget);
    int s0 = slv_cnt;
    int k = 0;
    while (slv_cnt == s0 && k < budget) begin
      tick();
      k++;
    end
    chk("slv_seen", (slv_cnt != s0) ? 1 : 0, 1);
  endtask

  // Bench slave: answers each issue after a latency, unless muted.
  initial begin
    int          cd = 0;
    logic [15:0] resp = 16'h0000;
    slv_bus.rdy = 1'b0;
    slv_bus.rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      slv_bus.rdy = 1'b0;
      slv_bus.rdata = 16'h0000;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          slv_bus.rdy = 1'b1;
          slv_bus.rdata = resp;
        end
      end
      if (slv_bus.init_txn === 1'b1 && !slv_mute) begin
        cd = slv_rand ? int'($urandom_range(1, 6)) : slv_lat;
        resp = slv_fix_en ? slv_fix_val : (slv_bus.addr ^ 16'h5A5A);
      end
    end
  end

  // Monitor: arbitration/issue check and completion scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (arst_n) begin
        if (slv_bus.init_txn === 1'b1) begin
          bit e0, e1;
          int w;
          req_t h;
          e0 = (q0.size() > 0) && !inflight0 && (q0[0].c <= cyc - 2);
          e1 = (q1.size() > 0) && !inflight1 && (q1[0].c <= cyc - 2);
          if (!e0 && !e1) begin
            chk("slv_unexpected", 1, 0);
          end else begin
            if (e0 && e1) begin
`ifdef STI_ARB_RR_EN
              w = last_g ? 0 : 1;
`else
              w = 0;
`endif
            end else begin
              w = e0 ? 0 : 1;
            end
            h = (w == 0) ? q0[0] : q1[0];
            chk("slv_wtxn", slv_bus.wtxn, h.w);
            chk("slv_addr", slv_bus.addr, h.a);
            chk("slv_wdata", slv_bus.wdata, h.d);
            if (w == 0) inflight0 = 1'b1;
            else        inflight1 = 1'b1;
            owner = w;
            last_g = w[0];
            slv_order.push_back(w);
            last_slv_cyc = cyc;
          end
          slv_cnt++;
        end
        if (m0_bus.rdy === 1'b1 || m1_bus.rdy === 1'b1) begin
          int g;
          g = (m0_bus.rdy === 1'b1) ? 0 : 1;
          chk("rdy_both", m0_bus.rdy & m1_bus.rdy, 0);
          chk("rdy_owner", g, owner);
          if (g == 0) begin
            chk("m1_idle_rdata", m1_bus.rdata, 0);
            if (q0.size() > 0 && inflight0) begin
              chk("m0_rdata", m0_bus.rdata, q0[0].r);
              void'(q0.pop_front());
            end else begin
              chk("m0_rdy_unexpected", 1, 0);
            end
            inflight0 = 1'b0;
            rdy_cnt0++;
            last_rdy_cyc0 = cyc;
          end else begin
            chk("m0_idle_rdata", m0_bus.rdata, 0);
            if (q1.size() > 0 && inflight1) begin
              chk("m1_rdata", m1_bus.rdata, q1[0].r);
              void'(q1.pop_front());
            end else begin
              chk("m1_rdy_unexpected", 1, 0);
            end
            inflight1 = 1'b0;
            rdy_cnt1++;
          end
          owner = -1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s0, r0, r1, t0;
    logic exp_first;
    m0_bus.init_txn = 1'b0; m0_bus.wtxn = 1'b0; m0_bus.addr = 16'h0000; m0_bus.wdata = 16'h0000;
    m1_bus.init_txn = 1'b0; m1_bus.wtxn = 1'b0; m1_bus.addr = 16'h0000; m1_bus.wdata = 16'h0000;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_slv_init", slv_bus.init_txn, 0);
    chk("rst_slv_wtxn", slv_bus.wtxn, 0);
    chk("rst_slv_addr", slv_bus.addr, 0);
    chk("rst_slv_wdata", slv_bus.wdata, 0);
    chk("rst_m0", {m0_bus.rdy, m0_bus.rdata}, 0);
    chk("rst_m1", {m1_bus.rdy, m1_bus.rdata}, 0);
    chk("rst_err", err, 0);
    arst_n = 1'b1;
    repeat (2) tick();

    // m0 read, fixed slave data, minimum latency
    slv_fix_en = 1'b1; slv_fix_val = 16'hABCD; slv_lat = 1;
    r1 = rdy_cnt1;
    n = cyc;
    issue(0, 1'b0, 16'h3000, 16'h0000, 1'b1);
    wait_idle(50);
    slv_fix_en = 1'b0;
    chk("t1_slv_cycle", last_slv_cyc - n, 2);
    chk("t1_rdy_cycle", last_rdy_cyc0 - n, 3);
    chk("t1_m1_quiet", rdy_cnt1 - r1, 0);

    // simultaneous writes, three tie rounds
    slv_lat = 2;
    for (int rnd = 0; rnd < 3; rnd++) begin
`ifdef STI_ARB_RR_EN
      exp_first = ~last_g;
`else
      exp_first = 1'b0;
`endif
      slv_order.delete();
      tick();
      issue(0, 1'b1, 16'h0010, 16'h1111, 1'b1);
      issue(1, 1'b1, 16'h0020, 16'h2222, 1'b1);
      wait_idle(60);
      chk("t2_count", slv_order.size(), 2);
      if (slv_order.size() == 2) begin
        chk("t2_first", slv_order[0], {31'd0, exp_first});
        chk("t2_second", slv_order[1], {31'd0, ~exp_first});
      end
    end

    // init coincident with own completion
    slv_lat = 1;
    s0 = slv_cnt; r0 = rdy_cnt0;
    tick();
    issue(0, 1'b0, 16'h0110, 16'h0000, 1'b1);
    repeat (3) tick();
    issue(0, 1'b1, 16'h0120, 16'h7777, 1'b1);
    wait_idle(50);
    chk("t6_slv_txns", slv_cnt - s0, 2);
    chk("t6_m0_rdys", rdy_cnt0 - r0, 2);

    // overrun on m1
    slv_lat = 4;
    s0 = slv_cnt; r1 = rdy_cnt1;
    tick();
    issue(1, 1'b0, 16'h0400, 16'h0000, 1'b1);
    tick();
    issue(1, 1'b1, 16'h0500, 16'h9999, 1'b0);
    wait_idle(50);
    repeat (4) tick();
    chk("t3_err", err, err_exp);
    chk("t3_slv_txns", slv_cnt - s0, 1);
    chk("t3_m1_rdys", rdy_cnt1 - r1, 1);

    // reset during WAIT, stale slave completion afterwards
    do_reset();
    slv_lat = 5;
    s0 = slv_cnt; r0 = rdy_cnt0; r1 = rdy_cnt1;
    tick();
    issue(0, 1'b0, 16'h0700, 16'h0000, 1'b1);
    wait_slv(20);
    do_reset();
    s0 = slv_cnt;
    repeat (10) tick();
    chk("t5_no_rdy", (rdy_cnt0 - r0) + (rdy_cnt1 - r1), 0);
    chk("t5_no_issue", slv_cnt - s0, 0);
    chk("t5_err", err, 0);

    // timeout, then the next pending request is served normally
    slv_mute = 1'b1;
    r1 = rdy_cnt1;
    tick();
    issue(0, 1'b0, 16'h0900, 16'h0000, 1'b1);
    wait_slv(20);
    t0 = last_slv_cyc;
    slv_mute = 1'b0;
    slv_lat = 2;
    issue(1, 1'b0, 16'h0A00, 16'h0000, 1'b1);
    wait_idle(80);
    chk("t4_rdy_cycle", last_rdy_cyc0 - t0, TO);
    chk("t4_err", err, 1);
    chk("t4_m1_served", rdy_cnt1 - r1, 1);

    // randomized traffic
    do_reset();
    slv_rand = 1'b1;
    s0 = slv_cnt; r0 = rdy_cnt0; r1 = rdy_cnt1;
    n = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (q0.size() == 0 && $urandom_range(0, 3) == 0) begin
        issue(0, 1'($urandom), 16'($urandom), 16'($urandom), 1'b1);
        n++;
      end
      if (q1.size() == 0 && $urandom_range(0, 3) == 0) begin
        issue(1, 1'($urandom), 16'($urandom), 16'($urandom), 1'b1);
        n++;
      end
    end
    wait_idle(100);
    chk("rand_slv_txns", slv_cnt - s0, n);
    chk("rand_rdys", (rdy_cnt0 - r0) + (rdy_cnt1 - r1), n);
    chk("rand_err", err, err_exp);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
